s_aes_engine: RTL and testbench
===============================

S_AES_ENGINE -- requirements
Module: s_aes_engine

Interface
REQ-001 SHALL have parameter KEY_REUSE, default 1: when 1, skip key expansion if the key equals the last expanded key.
REQ-002 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1: request present.
REQ-005 SHALL have port in_ready, output, 1: engine can accept a request.
REQ-006 SHALL have port in_decrypt, input, 1: 0 = encrypt, 1 = decrypt.
REQ-007 SHALL have port in_text, input, 16: plaintext or ciphertext block.
REQ-008 SHALL have port in_key, input, 16: initial key.
REQ-009 SHALL have port out_valid, output, 1: result present.
REQ-010 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-011 SHALL have port out_text, output, 16: result block.
REQ-012 SHALL have port busy, output, 1: state is not IDLE.

Function
REQ-013 SHALL implement a state machine with states IDLE, KEYX, R0, R1, R2, DONE.
REQ-014 SHALL drive in_ready = (state == IDLE).
REQ-015 SHALL accept on in_valid & in_ready and capture in_text, in_key and in_decrypt in the same cycle.
REQ-016 SHALL, from IDLE on accept, go to KEYX, or go directly to R0 when KEY_REUSE=1, the key cache is valid and in_key equals the cached key.
REQ-017 SHALL, in KEYX, register K1 and K2 from the standard S-AES expansion (RCON 0x80, 0x30), update the key cache and set it valid.
REQ-018 SHALL perform encrypt as: R0 AddRoundKey(K0); R1 NibbleSub, ShiftRows, MixColumns, AddKey(K1); R2 NibbleSub, ShiftRows, AddKey(K2).
REQ-019 SHALL perform decrypt as: R0 AddKey(K2); R1 InvShiftRows, InvNibbleSub, AddKey(K1), InvMixColumns; R2 InvShiftRows, InvNibbleSub, AddKey(K0).
REQ-020 SHALL have latency from accept to the first out_valid cycle of 4 cycles, or 3 cycles on a key-cache hit.
REQ-021 SHALL, in DONE, hold out_valid=1 and out_text stable until out_ready; on out_valid & out_ready, go to IDLE.
REQ-022 SHALL hold out_text at its last value while out_valid=0.
REQ-023 SHALL ignore in_valid while busy; no request is lost, because in_ready=0.
REQ-024 SHALL not accept a new request in the DONE/out_ready cycle; earliest accept is the following cycle.
REQ-025 SHALL perform all arithmetic in GF(2^4) with polynomial x^4+x+1, with nibble ordering as in standard S-AES (bits 15:12 = nibble 0).

Reset
REQ-026 SHALL, on rst_n low (asynchronous), set state=IDLE, out_valid=0, out_text=0, key cache invalid and cached key 0.
REQ-027 SHALL discard any in-flight operation on reset and produce no output for it.

Configuration
REQ-028 SHALL, with macro S_AES_CBC_EN defined, add input ports iv_load (1) and iv (16) and a 16-bit chain register.
REQ-029 SHALL, with S_AES_CBC_EN, load iv into chain on iv_load in IDLE; iv_load SHALL be ignored when not in IDLE and SHALL take priority over a same-cycle accept, whose chaining then uses the new iv.
REQ-030 SHALL, with S_AES_CBC_EN, encrypt in_text XOR chain, then set chain to the ciphertext; decrypt SHALL output the decrypted value XOR chain, then set chain to in_text.
REQ-031 SHALL reset chain to 0.
REQ-032 SHALL, without S_AES_CBC_EN, omit iv_load and iv and operate as pure ECB.

Structure
REQ-033 SHALL place in package s_aes_pkg: S-box and inverse S-box tables, RCON constants, the state enum type, and GF(2^4) multiply-by-2/4/9 functions.
REQ-034 SHALL use one sub-module, s_aes_keyexp, that combinationally produces K1 and K2 from K0.

Verification
REQ-035 SHALL verify encrypt with in_text 0x6F6B, key 0xA73B -> out_text 0x0738, out_valid 4 cycles after accept.
REQ-036 SHALL verify decrypt with in_text 0x0738, key 0xA73B -> out_text 0x6F6B; a second request with the same key -> latency 3 (KEY_REUSE=1).
REQ-037 SHALL verify backpressure: out_ready held 0 for 5 cycles -> out_valid and out_text stable, in_ready=0 throughout, in_valid pulses ignored.
REQ-038 SHALL verify reset: rst_n low during R1 -> out_valid=0 and in_ready=1 immediately; the next same-key request has latency 4 (cache invalidated).
REQ-039 SHALL verify CBC (S_AES_CBC_EN): iv 0x0000, encrypt 0x6F6B then 0x6F6B with key 0xA73B -> first out 0x0738, second out = E(0x6F6B XOR 0x0738).
REQ-040 SHALL verify CBC decrypt: same iv and key, decrypt the two ciphertexts -> returns 0x6F6B twice.

Source files
------------

// File: rtl/s_aes_pkg.sv
// s_aes_pkg -- shared definitions for the simplified-AES (S-AES) engine.
//   * engine state enum
//   * S-box / inverse S-box tables and key-schedule round constants
//   * GF(2^4) multiply helpers (polynomial x^4 + x + 1)
//   * whole-block round primitives; nibble 0 is bits 15:12
// No ports (package).
package s_aes_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_KEYX = 3'd1,
      ST_R0   = 3'd2,
      ST_R1   = 3'd3,
      ST_R2   = 3'd4,
      ST_DONE = 3'd5
   } state_t;

   localparam logic [7:0] RCON1 = 8'h80;
   localparam logic [7:0] RCON2 = 8'h30;

   localparam logic [3:0] SBOX [16] = '{
      4'h9, 4'h4, 4'hA, 4'hB, 4'hD, 4'h1, 4'h8, 4'h5,
      4'h6, 4'h2, 4'h0, 4'h3, 4'hC, 4'hE, 4'hF, 4'h7
   };

   localparam logic [3:0] INV_SBOX [16] = '{
      4'hA, 4'h5, 4'h9, 4'hB, 4'h1, 4'h7, 4'h8, 4'hF,
      4'h6, 4'h0, 4'h2, 4'h3, 4'hC, 4'h4, 4'hD, 4'hE
   };

   // x*2 reduced by x^4+x+1: a carry out of bit 3 folds back as 0x3
   function automatic logic [3:0] gf_mul2(input logic [3:0] a);
      return {a[2:0], 1'b0} ^ (a[3] ? 4'h3 : 4'h0);
   endfunction

   function automatic logic [3:0] gf_mul4(input logic [3:0] a);
      return gf_mul2(gf_mul2(a));
   endfunction

   function automatic logic [3:0] gf_mul9(input logic [3:0] a);
      return gf_mul2(gf_mul4(a)) ^ a;
   endfunction

   function automatic logic [7:0] sub_nib8(input logic [7:0] w);
      return {SBOX[w[7:4]], SBOX[w[3:0]]};
   endfunction

   function automatic logic [15:0] sub_nib16(input logic [15:0] x);
      return {SBOX[x[15:12]], SBOX[x[11:8]], SBOX[x[7:4]], SBOX[x[3:0]]};
   endfunction

   function automatic logic [15:0] inv_sub_nib16(input logic [15:0] x);
      return {INV_SBOX[x[15:12]], INV_SBOX[x[11:8]], INV_SBOX[x[7:4]], INV_SBOX[x[3:0]]};
   endfunction

   // Swaps nibbles 1 and 3 (second matrix row); it is its own inverse
   function automatic logic [15:0] shift_rows(input logic [15:0] x);
      return {x[15:12], x[3:0], x[7:4], x[11:8]};
   endfunction

   // Columns are (n0,n1) and (n2,n3); matrix [1 4; 4 1]
   function automatic logic [15:0] mix_cols(input logic [15:0] x);
      return {x[15:12] ^ gf_mul4(x[11:8]),
              gf_mul4(x[15:12]) ^ x[11:8],
              x[7:4] ^ gf_mul4(x[3:0]),
              gf_mul4(x[7:4]) ^ x[3:0]};
   endfunction

   // Inverse matrix [9 2; 2 9]
   function automatic logic [15:0] inv_mix_cols(input logic [15:0] x);
      return {gf_mul9(x[15:12]) ^ gf_mul2(x[11:8]),
              gf_mul2(x[15:12]) ^ gf_mul9(x[11:8]),
              gf_mul9(x[7:4]) ^ gf_mul2(x[3:0]),
              gf_mul2(x[7:4]) ^ gf_mul9(x[3:0])};
   endfunction

endpackage

// File: rtl/s_aes_keyexp.sv
// s_aes_keyexp -- combinational S-AES key expansion.
// Ports:
//   k0 (in, 16)  : initial key
//   k1 (out, 16) : round-1 key {w2, w3}
//   k2 (out, 16) : round-2 key {w4, w5}
module s_aes_keyexp
   import s_aes_pkg::*;
(
   input  logic [15:0] k0,
   output logic [15:0] k1,
   output logic [15:0] k2
);

   logic [7:0] w2_s;
   logic [7:0] w3_s;
   logic [7:0] w4_s;
   logic [7:0] w5_s;

   // g(w) = SubNib(RotNib(w)) ^ RCON; RotNib swaps the two nibbles of a word
   assign w2_s = k0[15:8] ^ RCON1 ^ sub_nib8({k0[3:0], k0[7:4]});
   assign w3_s = w2_s ^ k0[7:0];
   assign w4_s = w2_s ^ RCON2 ^ sub_nib8({w3_s[3:0], w3_s[7:4]});
   assign w5_s = w4_s ^ w3_s;

   assign k1 = {w2_s, w3_s};
   assign k2 = {w4_s, w5_s};

endmodule

// File: rtl/s_aes_engine.sv
// s_aes_engine -- multi-cycle S-AES encrypt/decrypt engine with key cache.
// Optional CBC chaining is enabled by defining macro S_AES_CBC_EN.
// Parameter KEY_REUSE (default 1): skip key expansion when the key matches
// the last expanded key.
// Ports:
//   clk, rst_n            : clock (rising edge), async active-low reset
//   in_valid / in_ready   : request handshake (in_ready only in IDLE)
//   in_decrypt            : 0 = encrypt, 1 = decrypt
//   in_text, in_key       : 16-bit block and initial key
//   out_valid / out_ready : result handshake; out_text held until accepted
//   out_text              : 16-bit result
//   iv_load, iv           : (S_AES_CBC_EN only) load chain register in IDLE
//   busy                  : engine not in IDLE
module s_aes_engine
   import s_aes_pkg::*;
#(
   parameter int KEY_REUSE = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_decrypt,
   input  logic [15:0] in_text,
   input  logic [15:0] in_key,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_text,
`ifdef S_AES_CBC_EN
   input  logic        iv_load,
   input  logic [15:0] iv,
`endif
   output logic        busy
);

   state_t      state_r;
   state_t      next_state_s;
   logic        accept_s;
   logic        hit_s;
   logic [15:0] data_r;
   logic [15:0] key_r;
   logic        dec_r;
   logic [15:0] k1_r;
   logic [15:0] k2_r;
   logic [15:0] k1_s;
   logic [15:0] k2_s;
   logic [15:0] cache_key_r;
   logic        cache_valid_r;
   logic [15:0] round_s;
   logic [15:0] pre_s;
   logic [15:0] result_s;
   logic        out_valid_r;
   logic [15:0] out_text_r;

   assign in_ready  = (state_r == ST_IDLE);
   assign busy      = (state_r != ST_IDLE);
   assign out_valid = out_valid_r;
   assign out_text  = out_text_r;
   assign accept_s  = in_valid & in_ready;
   assign hit_s     = (KEY_REUSE != 0) && cache_valid_r && (in_key == cache_key_r);

   s_aes_keyexp u_keyexp (
      .k0 (key_r),
      .k1 (k1_s),
      .k2 (k2_s)
   );

`ifdef S_AES_CBC_EN
   logic [15:0] chain_r;
   logic [15:0] text_r;
   logic [15:0] chain_eff_s;

   // A same-cycle iv_load wins, so the accepted block chains with the new iv
   assign chain_eff_s = iv_load ? iv : chain_r;
   assign pre_s       = in_decrypt ? in_text : (in_text ^ chain_eff_s);
   assign result_s    = dec_r ? (round_s ^ chain_r) : round_s;

   // Chain register: iv load in IDLE, next chaining value when the result is produced
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain_r <= 16'h0000;
         text_r  <= 16'h0000;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (iv_load) begin
                  chain_r <= iv;
               end
               if (accept_s) begin
                  text_r <= in_text;
               end
            end
            ST_R2: chain_r <= dec_r ? text_r : round_s;
            default: begin
               chain_r <= chain_r;
            end
         endcase
      end
   end
`else
   assign pre_s    = in_text;
   assign result_s = round_s;
`endif

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // FSM next-state logic
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               next_state_s = hit_s ? ST_R0 : ST_KEYX;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_KEYX: next_state_s = ST_R0;
         ST_R0:   next_state_s = ST_R1;
         ST_R1:   next_state_s = ST_R2;
         ST_R2:   next_state_s = ST_DONE;
         ST_DONE: begin
            if (out_ready) begin
               next_state_s = ST_IDLE;
            end else begin
               next_state_s = ST_DONE;
            end
         end
         default: next_state_s = ST_IDLE;
      endcase
   end

   // Round transformation selected by the current round state and direction
   always_comb begin
      round_s = data_r;
      case (state_r)
         ST_R0: begin
            if (dec_r) begin
               round_s = data_r ^ k2_r;
            end else begin
               round_s = data_r ^ key_r;
            end
         end
         ST_R1: begin
            if (dec_r) begin
               round_s = inv_mix_cols(inv_sub_nib16(shift_rows(data_r)) ^ k1_r);
            end else begin
               round_s = mix_cols(shift_rows(sub_nib16(data_r))) ^ k1_r;
            end
         end
         ST_R2: begin
            if (dec_r) begin
               round_s = inv_sub_nib16(shift_rows(data_r)) ^ key_r;
            end else begin
               round_s = shift_rows(sub_nib16(data_r)) ^ k2_r;
            end
         end
         default: round_s = data_r;
      endcase
   end

   // Block datapath: capture request on accept, then advance one round per state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_r <= 16'h0000;
         key_r  <= 16'h0000;
         dec_r  <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  data_r <= pre_s;
                  key_r  <= in_key;
                  dec_r  <= in_decrypt;
               end
            end
            ST_R0, ST_R1, ST_R2: data_r <= round_s;
            default: data_r <= data_r;
         endcase
      end
   end

   // Round keys and key cache; K1/K2 only change together with the cached key
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k1_r          <= 16'h0000;
         k2_r          <= 16'h0000;
         cache_key_r   <= 16'h0000;
         cache_valid_r <= 1'b0;
      end else if (state_r == ST_KEYX) begin
         k1_r          <= k1_s;
         k2_r          <= k2_s;
         cache_key_r   <= key_r;
         cache_valid_r <= 1'b1;
      end else begin
         cache_valid_r <= cache_valid_r;
      end
   end

   // Output registers: valid mirrors DONE, text only changes when a result lands
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_r <= 1'b0;
         out_text_r  <= 16'h0000;
      end else begin
         out_valid_r <= (next_state_s == ST_DONE);
         if (state_r == ST_R2) begin
            out_text_r <= result_s;
         end
      end
   end

endmodule

// File: tb/tb_s_aes_engine.sv
// tb_s_aes_engine -- scoreboard bench for s_aes_engine.
// Stimulus pushes expected {text, latency, accept cycle} into a queue; a
// negedge monitor pops and compares on each output handshake. Expected
// values come from a generic S-AES model (matrix GF(2^4) arithmetic).
// Builds with or without S_AES_CBC_EN.
module tb_s_aes_engine;

   localparam int KR = 1;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        in_decrypt = 1'b0;
   logic [15:0] in_text = 16'h0;
   logic [15:0] in_key = 16'h0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] out_text;
   logic        busy;
`ifdef S_AES_CBC_EN
   logic        iv_load = 1'b0;
   logic [15:0] iv = 16'h0;
`endif

   s_aes_engine #(.KEY_REUSE(KR)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_decrypt (in_decrypt),
      .in_text    (in_text),
      .in_key     (in_key),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_text   (out_text),
`ifdef S_AES_CBC_EN
      .iv_load    (iv_load),
      .iv         (iv),
`endif
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad = 0;
   int rdy_mode = 1;   // 0 random, 1 always ready, 2 hold off

   typedef struct {
      logic [15:0] text;
      int          lat;
      int          acc;
   } exp_t;
   exp_t q[$];

   // model state
   bit          m_cv = 1'b0;
   logic [15:0] m_ck = 16'h0;
   logic [15:0] m_chain = 16'h0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, req, $time);
      end
   endtask

   // ---------------- reference model ----------------
   localparam logic [3:0] SB [16] = '{
      4'h9, 4'h4, 4'hA, 4'hB, 4'hD, 4'h1, 4'h8, 4'h5,
      4'h6, 4'h2, 4'h0, 4'h3, 4'hC, 4'hE, 4'hF, 4'h7
   };

   function automatic logic [3:0] isb(input logic [3:0] x);
      logic [3:0] r = 4'h0;
      for (int j = 0; j < 16; j++) if (SB[j] == x) r = 4'(j);
      return r;
   endfunction

   function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 4; i++) if (b[i]) p = p ^ ({4'h0, a} << i);
      for (int i = 7; i >= 4; i--) if (p[i]) p = p ^ (8'h13 << (i - 4));
      return p[3:0];
   endfunction

   function automatic logic [15:0] sub_all(input logic [15:0] s, input bit inv);
      logic [15:0] r = 16'h0;
      for (int i = 0; i < 4; i++) r[4*i +: 4] = inv ? isb(s[4*i +: 4]) : SB[s[4*i +: 4]];
      return r;
   endfunction

   function automatic logic [15:0] shr(input logic [15:0] s);
      logic [3:0] n [4];
      logic [3:0] t;
      for (int i = 0; i < 4; i++) n[i] = s[15-4*i -: 4];
      t = n[1]; n[1] = n[3]; n[3] = t;
      return {n[0], n[1], n[2], n[3]};
   endfunction

   function automatic logic [15:0] mm(input logic [15:0] s, input logic [3:0] a, input logic [3:0] b,
                                      input logic [3:0] c, input logic [3:0] d);
      logic [3:0] n [4];
      logic [3:0] r [4];
      for (int i = 0; i < 4; i++) n[i] = s[15-4*i -: 4];
      for (int j = 0; j < 2; j++) begin
         r[2*j]   = gmul(a, n[2*j]) ^ gmul(b, n[2*j+1]);
         r[2*j+1] = gmul(c, n[2*j]) ^ gmul(d, n[2*j+1]);
      end
      return {r[0], r[1], r[2], r[3]};
   endfunction

   function automatic logic [31:0] kexp(input logic [15:0] k);
      logic [7:0] w [6];
      logic [7:0] rc [2];
      rc[0] = 8'h80; rc[1] = 8'h30;
      w[0] = k[15:8]; w[1] = k[7:0];
      for (int i = 2; i < 6; i++) begin
         if (i % 2 == 0) w[i] = w[i-2] ^ rc[i/2-1] ^ {SB[w[i-1][3:0]], SB[w[i-1][7:4]]};
         else            w[i] = w[i-2] ^ w[i-1];
      end
      return {w[2], w[3], w[4], w[5]};
   endfunction

   function automatic logic [15:0] menc(input logic [15:0] p, input logic [15:0] k);
      logic [31:0] ks = kexp(k);
      logic [15:0] s;
      s = p ^ k;
      s = mm(shr(sub_all(s, 1'b0)), 4'h1, 4'h4, 4'h4, 4'h1) ^ ks[31:16];
      s = shr(sub_all(s, 1'b0)) ^ ks[15:0];
      return s;
   endfunction

   function automatic logic [15:0] mdec(input logic [15:0] c, input logic [15:0] k);
      logic [31:0] ks = kexp(k);
      logic [15:0] s;
      s = c ^ ks[15:0];
      s = mm(sub_all(shr(s), 1'b1) ^ ks[31:16], 4'h9, 4'h2, 4'h2, 4'h9);
      s = sub_all(shr(s), 1'b1) ^ k;
      return s;
   endfunction

   // ---------------- stimulus helpers ----------------
   // fix_lat = 0 means "latency from model"
   task automatic send(input logic dec, input logic [15:0] txt, input logic [15:0] key,
                       input bit ivl, input logic [15:0] ivv,
                       input bit fix_en, input logic [15:0] fix_txt, input int fix_lat,
                       output logic [15:0] got);
      int w = 0;
      int lat;
      exp_t e;
      logic [15:0] r;
      got = 16'h0;
      @(negedge clk);
      in_valid = 1'b1; in_decrypt = dec; in_text = txt; in_key = key;
`ifdef S_AES_CBC_EN
      iv_load = ivl; iv = ivv;
`endif
      while (!in_ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      if (!in_ready) begin
         total++; bad++;
         $display("FAIL accept_timeout actual=busy expected=in_ready");
         in_valid = 1'b0;
         return;
      end
      lat = (KR != 0 && m_cv && key == m_ck) ? 3 : 4;
      m_cv = 1'b1; m_ck = key;
`ifdef S_AES_CBC_EN
      if (ivl) m_chain = ivv;
      if (!dec) begin
         r = menc(txt ^ m_chain, key);
         m_chain = r;
      end else begin
         r = mdec(txt, key) ^ m_chain;
         m_chain = txt;
      end
`else
      r = dec ? mdec(txt, key) : menc(txt, key);
      if (ivl && ivv != 16'h0) r = r;
`endif
      got = r;
      e.text = fix_en ? fix_txt : r;
      e.lat  = (fix_lat != 0) ? fix_lat : lat;
      e.acc  = cyc + 1;
      q.push_back(e);
      @(negedge clk);
      in_valid = 1'b0;
`ifdef S_AES_CBC_EN
      iv_load = 1'b0;
`endif
   endtask

   task automatic drain();
      int w = 0;
      while (q.size() != 0 && w < 400) begin
         @(negedge clk);
         w++;
      end
      if (q.size() != 0) begin
         total++; bad++;
         $display("FAIL drain_timeout actual=%0d expected=0 pending", q.size());
         q.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   // ready driver: changes away from both clock edges' sampling points
   initial begin
      forever begin
         @(posedge clk);
         #2;
         case (rdy_mode)
            0: out_ready = 1'($urandom_range(0, 1));
            1: out_ready = 1'b1;
            default: out_ready = 1'b0;
         endcase
      end
   end

   // ---------------- monitor / scoreboard ----------------
   logic        prev_valid = 1'b0;
   logic        prev_ready = 1'b0;
   logic [15:0] prev_text = 16'h0;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_valid = 1'b0;
         prev_ready = 1'b0;
         prev_text  = 16'h0;
      end else begin
         if (out_valid && !prev_valid) begin
            if (q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_out actual=%h expected=none", out_text);
            end else begin
               chk("latency", 32'(cyc - q[0].acc), 32'(q[0].lat));
            end
         end
         if (out_valid && prev_valid && !prev_ready) chk("hold_text", {16'h0, out_text}, {16'h0, prev_text});
         if (!out_valid) chk("idle_text", {16'h0, out_text}, {16'h0, prev_text});
         if (out_valid) chk("in_ready_low", {31'h0, in_ready}, 32'h0);
         if (out_valid && out_ready && q.size() != 0) begin
            chk("out_text", {16'h0, out_text}, {16'h0, q[0].text});
            void'(q.pop_front());
         end
         prev_valid = out_valid;
         prev_ready = out_ready;
         prev_text  = out_text;
      end
   end

   // ---------------- main sequence ----------------
   logic [15:0] got;
   logic [15:0] c1;
   logic [15:0] c2;
   logic [15:0] held;
   logic [15:0] pool [3];
   logic [15:0] k_new;

   initial begin
      #1;
      chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
      chk("rst_out_text", {16'h0, out_text}, 32'h0);
      chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      rdy_mode = 1;

      // known vector, then decrypt it twice with the cached key
      send(1'b0, 16'h6F6B, 16'hA73B, 1'b0, 16'h0, 1'b1, 16'h0738, 4, got);
      drain();
      send(1'b1, 16'h0738, 16'hA73B, 1'b1, 16'h0, 1'b1, 16'h6F6B, 3, got);
      drain();
      send(1'b1, 16'h0738, 16'hA73B, 1'b1, 16'h0, 1'b1, 16'h6F6B, 3, got);
      drain();

      // backpressure with ignored in_valid pulses
      rdy_mode = 2;
      send(1'b0, 16'h1234, 16'hA73B, 1'b0, 16'h0, 1'b0, 16'h0, 0, got);
      for (int w = 0; w < 20 && !out_valid; w++) @(negedge clk);
      chk("bp_valid_seen", {31'h0, out_valid}, 32'h1);
      held = out_text;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_valid", {31'h0, out_valid}, 32'h1);
         chk("bp_text", {16'h0, out_text}, {16'h0, held});
         chk("bp_in_ready", {31'h0, in_ready}, 32'h0);
         in_valid = ~in_valid;
         in_text = 16'($urandom);
      end
      in_valid = 1'b0;
      rdy_mode = 1;
      drain();

      // reset during R1 on a cache miss
      k_new = m_ck ^ 16'h5A5A;
      send(1'b0, 16'hBEEF, k_new, 1'b0, 16'h0, 1'b0, 16'h0, 0, got);
      repeat (2) @(negedge clk);
      chk("r1_busy", {31'h0, busy}, 32'h1);
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", {31'h0, out_valid}, 32'h0);
      chk("midrst_in_ready", {31'h0, in_ready}, 32'h1);
      q.delete();
      m_cv = 1'b0; m_ck = 16'h0; m_chain = 16'h0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      send(1'b0, 16'hBEEF, k_new, 1'b0, 16'h0, 1'b0, 16'h0, 4, got);
      drain();

`ifdef S_AES_CBC_EN
      // CBC encrypt/decrypt chain
      send(1'b0, 16'h6F6B, 16'hA73B, 1'b1, 16'h0, 1'b1, 16'h0738, 0, c1);
      send(1'b0, 16'h6F6B, 16'hA73B, 1'b0, 16'h0, 1'b1, menc(16'h6F6B ^ 16'h0738, 16'hA73B), 0, c2);
      drain();
      send(1'b1, c1, 16'hA73B, 1'b1, 16'h0, 1'b1, 16'h6F6B, 0, got);
      send(1'b1, c2, 16'hA73B, 1'b0, 16'h0, 1'b1, 16'h6F6B, 0, got);
      drain();
`endif

      // randomized traffic with random backpressure and a small key pool
      pool[0] = 16'hA73B;
      pool[1] = 16'($urandom);
      pool[2] = 16'($urandom);
      rdy_mode = 0;
      for (int n = 0; n < 40; n++) begin
         send(1'($urandom_range(0, 1)), 16'($urandom), pool[$urandom_range(0, 2)],
              ($urandom_range(0, 7) == 0), 16'($urandom), 1'b0, 16'h0, 0, got);
      end
      rdy_mode = 1;
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // hard time limit
   initial begin
      #200000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
